muldiv_seq: RTL and testbench

//  Multicycle MULT/DIV sequencer that borrows the shared N-bit ripple ALU (aluN) to run shift-add

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_sign.sv | 42 ++++
 rtl/muldiv_seq.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared state encoding, op codes and ALU opcode for muldiv_seq
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIX_IN,
        ITER,
        FIX_OUT,
        DONE
    } state_t;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [3:0] OP_ADD = 4'b0010;

endpackage

// File: rtl/muldiv_sign.sv
// rtl/muldiv_sign.sv - operand magnitude and signed result correction for muldiv_seq
// Instantiated only when MULDIV_SIGNED_EN is defined.
module muldiv_sign #(
    parameter int N = 32
) (
    input  logic         sign_a,
    input  logic         sign_b,
    input  logic         is_div,
    input  logic         dz,
    input  logic [N-1:0] a_raw,
    input  logic [N-1:0] b_raw,
    input  logic [N-1:0] hi,
    input  logic [N-1:0] lo,
    output logic [N-1:0] a_mag,
    output logic [N-1:0] b_mag,
    output logic [N-1:0] hi_fix,
    output logic [N-1:0] lo_fix
);

    logic [2*N-1:0] prod_neg;

    assign a_mag    = sign_a ? -a_raw : a_raw;
    assign b_mag    = sign_b ? -b_raw : b_raw;
    assign prod_neg = -{hi, lo};

    // Divide-by-zero keeps the all-ones quotient; the remainder sign fix alone restores rs.
    always_comb begin
        hi_fix = hi;
        lo_fix = lo;
        if (is_div) begin
            if (sign_a) begin
                hi_fix = -hi;
            end
            if ((sign_a ^ sign_b) && !dz) begin
                lo_fix = -lo;
            end
        end else if (sign_a ^ sign_b) begin
            {hi_fix, lo_fix} = prod_neg;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - shift-add multiply / restoring divide sequencer borrowing the shared ALU
// Signed MULT/DIV and the FIX_IN/FIX_OUT states exist only when MULDIV_SIGNED_EN is defined.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [N-1:0] rs_i,
    input  logic [N-1:0] rt_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] hi_o,
    output logic [N-1:0] lo_o,
    output logic         dz_o,
    output logic         alu_own_o,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    output logic [3:0]   alu_ope_o,
    output logic         alu_c_o,
    input  logic [N-1:0] alu_sal_i,
    input  logic         alu_c_i
);

    localparam int CNT_W = $clog2(N) + 1;

    state_t           state;
    state_t           next;
    logic [N-1:0]     hi_q;
    logic [N-1:0]     lo_q;
    logic [N-1:0]     m_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q;
    logic             dz_pend_q;
    logic             dz_q;
    logic [N-1:0]     div_rem;
    logic             div_ok;

    // Partial remainder shifted left with the next dividend bit; its top bit forces a subtract.
    assign div_rem = {hi_q[N-2:0], lo_q[N-1]};
    assign div_ok  = hi_q[N-1] | alu_c_i;

`ifdef MULDIV_SIGNED_EN
    logic         signed_q;
    logic         sign_a_q;
    logic         sign_b_q;
    logic [N-1:0] a_mag;
    logic [N-1:0] b_mag;
    logic [N-1:0] hi_fix;
    logic [N-1:0] lo_fix;

    muldiv_sign #(.N(N)) u_sign (
        .sign_a (sign_a_q),
        .sign_b (sign_b_q),
        .is_div (is_div_q),
        .dz     (dz_pend_q),
        .a_raw  (lo_q),
        .b_raw  (m_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .hi_fix (hi_fix),
        .lo_fix (lo_fix)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            signed_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else if (state == IDLE && start_i) begin
            signed_q <= op_i[1];
            sign_a_q <= op_i[1] & rs_i[N-1];
            sign_b_q <= op_i[1] & rt_i[N-1];
        end
    end
`else
    logic unused_op;
    assign unused_op = op_i[1];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
`ifdef MULDIV_SIGNED_EN
                    next = op_i[1] ? FIX_IN : ITER;
`else
                    next = ITER;
`endif
                end
            end
            FIX_IN:  next = ITER;
            ITER: begin
                if (cnt_q == '0) begin
`ifdef MULDIV_SIGNED_EN
                    next = signed_q ? FIX_OUT : DONE;
`else
                    next = DONE;
`endif
                end
            end
            FIX_OUT: next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q      <= '0;
            lo_q      <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            dz_pend_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        m_q       <= rt_i;
                        hi_q      <= '0;
                        lo_q      <= rs_i;
                        cnt_q     <= CNT_W'(N - 1);
                        is_div_q  <= op_i[0];
                        dz_pend_q <= op_i[0] && (rt_i == '0);
                    end
                end
                ITER: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (is_div_q) begin
                        hi_q <= div_ok ? alu_sal_i : div_rem;
                        lo_q <= {lo_q[N-2:0], div_ok};
                    end else begin
                        hi_q <= {alu_c_i, alu_sal_i[N-1:1]};
                        lo_q <= {alu_sal_i[0], lo_q[N-1:1]};
                    end
                end
`ifdef MULDIV_SIGNED_EN
                FIX_IN: begin
                    lo_q <= a_mag;
                    m_q  <= b_mag;
                end
                FIX_OUT: begin
                    hi_q <= hi_fix;
                    lo_q <= lo_fix;
                end
`endif
                default: ;
            endcase
            if (next == DONE && state != DONE) begin
                dz_q <= dz_pend_q;
            end
        end
    end

    always_comb begin
        busy_o    = (state != IDLE);
        done_o    = (state == DONE);
        alu_own_o = (state == ITER);
        alu_a_o   = '0;
        alu_b_o   = '0;
        alu_c_o   = 1'b0;
        alu_ope_o = OP_ADD;
        if (state == ITER) begin
            if (is_div_q) begin
                alu_a_o = div_rem;
                alu_b_o = m_q;
                alu_c_o = 1'b1;
            end else begin
                alu_a_o = hi_q;
                alu_b_o = lo_q[0] ? m_q : '0;
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
    assign dz_o = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq with a behavioural shared ALU and operand mux
`timescale 1ns/1ps
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int N = 32;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [N-1:0] rs;
        logic [N-1:0] rt;
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic       dz;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [N-1:0] rs_i = '0;
    logic [N-1:0] rt_i = '0;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] hi_o;
    logic [N-1:0] lo_o;
    logic         dz_o;
    logic         alu_own_o;
    logic [N-1:0] alu_a_o;
    logic [N-1:0] alu_b_o;
    logic [3:0]   alu_ope_o;
    logic         alu_c_o;
    logic [N-1:0] alu_sal;
    logic         alu_co;
    logic [N-1:0] mux_a;
    logic [N-1:0] mux_b;
    logic         mux_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.N(N)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .start_i   (start_i),
        .op_i      (op_i),
        .rs_i      (rs_i),
        .rt_i      (rt_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .dz_o      (dz_o),
        .alu_own_o (alu_own_o),
        .alu_a_o   (alu_a_o),
        .alu_b_o   (alu_b_o),
        .alu_ope_o (alu_ope_o),
        .alu_c_o   (alu_c_o),
        .alu_sal_i (alu_sal),
        .alu_c_i   (alu_co)
    );

    // Shared ALU: the other master is idle (zeros) whenever the sequencer does not own the mux.
    assign mux_a = alu_own_o ? alu_a_o : '0;
    assign mux_b = alu_own_o ? alu_b_o : '0;
    assign mux_c = alu_own_o ? alu_c_o : 1'b0;
    assign {alu_co, alu_sal} = {1'b0, mux_a} + {1'b0, (mux_c ? ~mux_b : mux_b)} + {{N{1'b0}}, mux_c};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op);
        int lat;
        lat = N + 1;
`ifdef MULDIV_SIGNED_EN
        if (op[1]) lat = N + 3;
`endif
        return lat;
    endfunction

    task automatic model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] hi, output logic [N-1:0] lo, output logic dz);
        logic [63:0] p;
        bit          sgn;
        longint      sa;
        longint      sb;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = op[1];
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = op[0] && (b == 0);
        if (!op[0]) begin
            p  = sgn ? 64'(sa * sb) : (64'(a) * 64'(b));
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 0) begin
            lo = '1;
            hi = a;
        end else if (sgn) begin
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    // Entered at #1 after a rising edge with the DUT idle; returns at the same phase, idle again.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] ehi, input logic [N-1:0] elo,
                          input logic edz, input bit poke);
        int cyc;
        bit seen;
        start_i = 1'b1;
        op_i    = op;
        rs_i    = a;
        rt_i    = b;
        cyc     = 0;
        seen    = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            cyc++;
            if (done_o) seen = 1'b1;
        end
        check({tag, "_done"}, 64'(seen), 64'(1));
        check({tag, "_lat"}, 64'(cyc), 64'(exp_lat(op)));
        check({tag, "_hi"}, 64'(hi_o), 64'(ehi));
        check({tag, "_lo"}, 64'(lo_o), 64'(elo));
        check({tag, "_dz"}, 64'(dz_o), 64'(edz));
        if (poke) begin
            start_i = 1'b1;
            op_i    = OP_DIVU;
            rs_i    = 32'd5;
            rt_i    = 32'd1;
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check({tag, "_pulse"}, 64'(done_o), 64'(0));
        check({tag, "_idle"}, 64'(busy_o), 64'(0));
        if (poke) begin
            check({tag, "_hold_hi"}, 64'(hi_o), 64'(ehi));
            check({tag, "_hold_lo"}, 64'(lo_o), 64'(elo));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[$];
        logic [N-1:0] ehi;
        logic [N-1:0] elo;
        logic         edz;
        logic [1:0]   rop;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        #3;
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_dz",   64'(dz_o),   64'(0));
        check("rst_own",  64'(alu_own_o), 64'(0));
        check("rst_c",    64'(alu_c_o), 64'(0));
        check("rst_hilo", {hi_o, lo_o}, 64'(0));
        check("rst_ab",   {alu_a_o, alu_b_o}, 64'(0));
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        tbl.push_back('{"mul7x6",   OP_MULTU, 32'd7,        32'd6,        32'h0,        32'd42,       1'b0});
        tbl.push_back('{"mulmax",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
        tbl.push_back('{"div100_7", OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0});
        tbl.push_back('{"div8M_3",  OP_DIVU,  32'h80000000, 32'd3,        32'd2,        32'h2AAAAAAA, 1'b0});
        tbl.push_back('{"div_z",    OP_DIVU,  32'd1234,     32'd0,        32'd1234,     32'hFFFFFFFF, 1'b1});
        tbl.push_back('{"mul0",     OP_MULTU, 32'd0,        32'hDEADBEEF, 32'h0,        32'h0,        1'b0});
        tbl.push_back('{"div_lt",   OP_DIVU,  32'd3,        32'd9,        32'd3,        32'd0,        1'b0});
`ifdef MULDIV_SIGNED_EN
        tbl.push_back('{"smul",     OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
        tbl.push_back('{"sdiv",     OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        tbl.push_back('{"sdiv_z",   OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1});
        tbl.push_back('{"sdiv_min", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0});
`else
        tbl.push_back('{"smul_u",   OP_MULT,  32'hFFFFFFFD, 32'd5,        32'h4,        32'hFFFFFFF1, 1'b0});
        tbl.push_back('{"sdiv_u",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h1,        32'h7FFFFFFC, 1'b0});
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i].name, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo, tbl[i].dz, 1'b0);
        end

        // start_i raised in the DONE cycle must be ignored and results held
        run_op("poke", OP_MULTU, 32'd1000, 32'd1000, 32'h0, 32'd1000000, 1'b0, 1'b1);

        // Abort mid-divide with start_i held, after a divide-by-zero left dz_o set
        run_op("pre_dz", OP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1, 1'b0);
        start_i = 1'b1;
        op_i    = OP_DIVU;
        rs_i    = 32'd1000;
        rt_i    = 32'd3;
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        check("abort_busy", 64'(busy_o), 64'(1));
        check("abort_own",  64'(alu_own_o), 64'(1));
        check("abort_c",    64'(alu_c_o), 64'(1));
        check("abort_ope",  64'(alu_ope_o), 64'(OP_ADD));
        check("abort_dz",   64'(dz_o), 64'(1));
        rst_ni  = 1'b0;
        start_i = 1'b0;
        #1;
        check("abort_rst_busy", 64'(busy_o), 64'(0));
        check("abort_rst_ctl",  {60'(0), done_o, dz_o, alu_own_o, alu_c_o}, 64'(0));
        check("abort_rst_hilo", {hi_o, lo_o}, 64'(0));
        check("abort_rst_ab",   {alu_a_o, alu_b_o}, 64'(0));
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        run_op("post_rst", OP_MULTU, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 5000));
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1, 2:    rb = 32'($urandom_range(1, 300));
                default: rb = 32'($urandom);
            endcase
            model(rop, ra, rb, ehi, elo, edz);
            run_op($sformatf("rnd%0d", i), rop, ra, rb, ehi, elo, edz, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
